gemm_tile_sequencer: RTL and testbench

- Synthesizable, parametrised front-end for the GEMM systolic array; replaces the fixed-pattern driver FSM used in formal harnesses.
- Accepts a weight tile and a runtime-sized batch of activation rows over valid/ready streams, and issues the GEMM command sequence (write weights, stream, drain).
- Captures the GEMM result rows into an output FIFO and presents them on a valid/ready stream with last marking.
- Backpressure is handled by freezing the array (CMD_NONE) rather than dropping data.

---
 rtl/gemm_tile_sequencer_pkg.sv | 11 +
 rtl/gemm_tile_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_gemm_tile_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gemm_tile_sequencer_pkg.sv
// Shared types for the GEMM tile sequencer and its GEMM array interface.
package gemm_tile_sequencer_pkg;

    // Command encoding understood by the GEMM systolic array.
    typedef enum logic [1:0] {
        CMD_NONE          = 2'd0,
        CMD_WRITE_WEIGHTS = 2'd1,
        CMD_STREAM        = 2'd2
    } command_t;

endpackage

// File: rtl/gemm_tile_sequencer.sv
// GEMM tile sequencer: loads a weight tile, streams a batch of activation
// rows into the systolic array and collects result rows into an output FIFO.
// Backpressure freezes the array (CMD_NONE) instead of dropping rows.
// Optional feature macro: GEMM_TILE_SEQ_WEIGHT_REUSE_EN (adds keep_weights,
// lets a job reuse the tile left in the array by a previously completed job).
module gemm_tile_sequencer
    import gemm_tile_sequencer_pkg::*;
#(
    parameter int SA_SIZE                = 4,
    parameter int WEIGHT_ACTIVATION_SIZE = 8,
    parameter int MAX_ROWS               = 16,
    parameter int OUT_FIFO_DEPTH         = 4
) (
    input  logic                                                 clk,
    input  logic                                                 resetn,
    input  logic                                                 start,
    input  logic [$clog2(MAX_ROWS+1)-1:0]                        num_rows,
`ifdef GEMM_TILE_SEQ_WEIGHT_REUSE_EN
    input  logic                                                 keep_weights,
`endif
    output logic                                                 busy,
    output logic                                                 done,
    input  logic                                                 w_valid,
    output logic                                                 w_ready,
    input  logic [SA_SIZE*WEIGHT_ACTIVATION_SIZE-1:0]            w_data,
    input  logic                                                 a_valid,
    output logic                                                 a_ready,
    input  logic [SA_SIZE*WEIGHT_ACTIVATION_SIZE-1:0]            a_data,
    output logic                                                 o_valid,
    input  logic                                                 o_ready,
    output logic [SA_SIZE*WEIGHT_ACTIVATION_SIZE-1:0]            o_data,
    output logic                                                 o_last,
    output command_t                                             gemm_cmd,
    output logic [SA_SIZE*SA_SIZE*WEIGHT_ACTIVATION_SIZE-1:0]    gemm_weights,
    output logic [SA_SIZE*WEIGHT_ACTIVATION_SIZE-1:0]            gemm_act,
    input  logic [SA_SIZE*WEIGHT_ACTIVATION_SIZE-1:0]            gemm_act_out,
    input  logic                                                 gemm_out_valid
);

    localparam int W   = WEIGHT_ACTIVATION_SIZE;
    localparam int RW  = $clog2(MAX_ROWS + 1);
    localparam int WCW = (SA_SIZE > 1) ? $clog2(SA_SIZE) : 1;
    localparam int PW  = $clog2(OUT_FIFO_DEPTH);
    localparam int CW  = $clog2(OUT_FIFO_DEPTH + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_W, S_WRITE_W, S_STREAM, S_DRAIN, S_DONE
    } state_t;

    state_t                              state_q;
    logic [WCW-1:0]                      w_cnt_q;
    logic [RW-1:0]                       in_cnt_q;
    logic [RW-1:0]                       out_cnt_q;
    logic [RW-1:0]                       eff_rows_q;
    logic [SA_SIZE-1:0][SA_SIZE*W-1:0]   w_q;
`ifdef GEMM_TILE_SEQ_WEIGHT_REUSE_EN
    logic                                job_done_q;
`endif

    // Output FIFO (first-word fall-through)
    logic [OUT_FIFO_DEPTH-1:0][SA_SIZE*W-1:0] mem_q;
    logic [OUT_FIFO_DEPTH-1:0]                last_q;
    logic [PW-1:0]                            rd_ptr_q;
    logic [PW-1:0]                            wr_ptr_q;
    logic [CW-1:0]                            cnt_q;

    logic          fifo_full, fifo_empty, pop, push, room;
    logic          issue, capture, out_pending, push_last, last_issue;
    logic [RW-1:0] eff_rows_d;
    command_t      cmd_d;

    assign fifo_full   = (cnt_q == CW'(OUT_FIFO_DEPTH));
    assign fifo_empty  = (cnt_q == '0);
    assign o_valid     = !fifo_empty;
    assign pop         = o_valid && o_ready;
    // A slot is available if the FIFO has room now or frees one this cycle.
    assign room        = !fifo_full || pop;
    assign out_pending = (out_cnt_q != eff_rows_q);
    assign push_last   = (out_cnt_q == eff_rows_q - RW'(1));
    assign last_issue  = (in_cnt_q == eff_rows_q - RW'(1));
    assign eff_rows_d  = (num_rows > RW'(MAX_ROWS)) ? RW'(MAX_ROWS) : num_rows;

    // Command decode: the array only advances when it can deliver into the FIFO.
    always_comb begin
        cmd_d = CMD_NONE;
        issue = 1'b0;
        case (state_q)
            S_WRITE_W: cmd_d = CMD_WRITE_WEIGHTS;
            S_STREAM: begin
                if (a_valid && room) begin
                    issue = 1'b1;
                    cmd_d = CMD_STREAM;
                end
            end
            S_DRAIN: begin
                if (out_pending && room) cmd_d = CMD_STREAM;
            end
            default: cmd_d = CMD_NONE;
        endcase
    end

    assign capture      = gemm_out_valid && (cmd_d == CMD_STREAM);
    // Captures beyond the job's row count are the array flushing drain rows.
    assign push         = capture && out_pending;

    assign gemm_cmd     = cmd_d;
    assign gemm_act     = issue ? a_data : '0;
    assign gemm_weights = w_q;
    assign a_ready      = issue;
    assign w_ready      = (state_q == S_LOAD_W);
    assign done         = (state_q == S_DONE);
    assign busy         = (state_q != S_IDLE) || start;
    assign o_data       = mem_q[rd_ptr_q];
    assign o_last       = !fifo_empty && last_q[rd_ptr_q];

    // Job sequencing FSM with weight capture and row counters.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            w_cnt_q    <= '0;
            in_cnt_q   <= '0;
            out_cnt_q  <= '0;
            eff_rows_q <= '0;
            w_q        <= '0;
`ifdef GEMM_TILE_SEQ_WEIGHT_REUSE_EN
            job_done_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        eff_rows_q <= eff_rows_d;
                        w_cnt_q    <= '0;
                        in_cnt_q   <= '0;
                        out_cnt_q  <= '0;
                        if (eff_rows_d == '0)
                            state_q <= S_DONE;
`ifdef GEMM_TILE_SEQ_WEIGHT_REUSE_EN
                        else if (keep_weights && job_done_q)
                            state_q <= S_STREAM;
`endif
                        else
                            state_q <= S_LOAD_W;
                    end
                end
                S_LOAD_W: begin
                    if (w_valid) begin
                        w_q[w_cnt_q] <= w_data;
                        w_cnt_q      <= w_cnt_q + WCW'(1);
                        if (w_cnt_q == WCW'(SA_SIZE - 1)) state_q <= S_WRITE_W;
                    end
                end
                S_WRITE_W: state_q <= S_STREAM;
                S_STREAM: begin
                    if (issue) begin
                        in_cnt_q <= in_cnt_q + RW'(1);
                        if (last_issue) state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (!out_pending && fifo_empty) state_q <= S_DONE;
                end
                S_DONE: begin
                    state_q <= S_IDLE;
`ifdef GEMM_TILE_SEQ_WEIGHT_REUSE_EN
                    job_done_q <= 1'b1;
`endif
                end
                default: state_q <= S_IDLE;
            endcase
            // Never in IDLE, so cannot collide with the counter clear above.
            if (push) out_cnt_q <= out_cnt_q + RW'(1);
        end
    end

    // FIFO pointers and occupancy; push and pop together keep the count.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // FIFO storage; contents are don't-care while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q]  <= gemm_act_out;
            last_q[wr_ptr_q] <= push_last;
        end
    end

endmodule

// File: tb/tb_gemm_tile_sequencer.sv
// Testbench for gemm_tile_sequencer: behavioural GEMM array model, directed
// jobs, and a scoreboard monitor checking every result row in order.
module tb_gemm_tile_sequencer;
    import gemm_tile_sequencer_pkg::*;

    localparam int SA  = 2;
    localparam int W   = 8;
    localparam int MR  = 16;
    localparam int FD  = 4;
    localparam int RW  = $clog2(MR + 1);
    localparam int LAT = 3;

    logic              clk = 1'b0;
    logic              resetn;
    logic              start;
    logic [RW-1:0]     num_rows;
    logic              busy, done;
    logic              w_valid, w_ready;
    logic [SA*W-1:0]   w_data;
    logic              a_valid, a_ready;
    logic [SA*W-1:0]   a_data;
    logic              o_valid, o_ready, o_last;
    logic [SA*W-1:0]   o_data;
    command_t          gemm_cmd;
    logic [SA*SA*W-1:0] gemm_weights;
    logic [SA*W-1:0]   gemm_act, gemm_act_out;
    logic              gemm_out_valid;
`ifdef GEMM_TILE_SEQ_WEIGHT_REUSE_EN
    logic              keep_w;
`endif

    always #5 clk = ~clk;

    gemm_tile_sequencer #(
        .SA_SIZE(SA), .WEIGHT_ACTIVATION_SIZE(W), .MAX_ROWS(MR), .OUT_FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .resetn(resetn), .start(start), .num_rows(num_rows),
`ifdef GEMM_TILE_SEQ_WEIGHT_REUSE_EN
        .keep_weights(keep_w),
`endif
        .busy(busy), .done(done),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
        .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data), .o_last(o_last),
        .gemm_cmd(gemm_cmd), .gemm_weights(gemm_weights), .gemm_act(gemm_act),
        .gemm_act_out(gemm_act_out), .gemm_out_valid(gemm_out_valid)
    );

    int total = 0;
    int passed = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    endtask

    function automatic logic [SA*W-1:0] mkrow(input int e0, input int e1);
        logic [SA*W-1:0] r;
        r[0 +: W] = e0[W-1:0];
        r[W +: W] = e1[W-1:0];
        return r;
    endfunction

    // GEMM array model: LAT-deep pipeline advancing only on CMD_STREAM,
    // rows tagged valid only when they carried an accepted activation.
    logic [SA*SA*W-1:0] mwt = '0;
    logic [LAT-1:0]     pv  = '0;
    logic [SA*W-1:0]    pd [LAT];

    function automatic logic [SA*W-1:0] gmul(input logic [SA*SA*W-1:0] wt, input logic [SA*W-1:0] a);
        logic [SA*W-1:0] r;
        logic [W-1:0]    acc;
        for (int c = 0; c < SA; c++) begin
            acc = '0;
            for (int k = 0; k < SA; k++) acc = acc + a[k*W +: W] * wt[(k*SA+c)*W +: W];
            r[c*W +: W] = acc;
        end
        return r;
    endfunction

    always @(posedge clk) begin
        if (gemm_cmd == CMD_WRITE_WEIGHTS) begin
            mwt <= gemm_weights;
            pv  <= '0;
        end else if (gemm_cmd == CMD_STREAM) begin
            pv    <= {pv[LAT-2:0], a_valid && a_ready};
            pd[0] <= gmul(mwt, gemm_act);
            for (int i = 1; i < LAT; i++) pd[i] <= pd[i-1];
        end
    end
    assign gemm_out_valid = pv[LAT-1];
    assign gemm_act_out   = pd[LAT-1];

    // Bench-side job data
    logic [SA*W-1:0] tw   [SA];
    logic [SA*W-1:0] arow [32];
    logic [SA*W-1:0] erow [32];

    function automatic logic [SA*W-1:0] ref_row(input logic [SA*W-1:0] a);
        logic [SA*W-1:0] r;
        logic [W-1:0]    acc;
        for (int c = 0; c < SA; c++) begin
            acc = '0;
            for (int k = 0; k < SA; k++) acc = acc + a[k*W +: W] * tw[k][c*W +: W];
            r[c*W +: W] = acc;
        end
        return r;
    endfunction

    typedef struct packed { logic [SA*W-1:0] d; logic l; } exp_t;
    exp_t exp_q[$];

    // Scoreboard monitor: compare every transferred result row.
    always @(negedge clk) begin
        if (resetn && o_valid && o_ready) begin
            if (exp_q.size() == 0) chk("o_unexpected_row", 64'(o_data), 64'hdead);
            else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("o_data", 64'(o_data), 64'(e.d));
                chk("o_last", 64'(o_last), 64'(e.l));
            end
        end
    end

    // Cycle observer: event counters and per-cycle interface invariants.
    int n_wr = 0, n_str = 0, n_wrdy = 0, n_whs = 0, n_ahs = 0, n_done = 0, n_viol = 0;
    always @(negedge clk) begin
        if (resetn) begin
            if (gemm_cmd == CMD_WRITE_WEIGHTS) n_wr++;
            if (gemm_cmd == CMD_STREAM) n_str++;
            if (w_ready) n_wrdy++;
            if (w_valid && w_ready) n_whs++;
            if (a_valid && a_ready) n_ahs++;
            if (done) n_done++;
            if (a_ready && !(a_valid && gemm_cmd == CMD_STREAM && gemm_act == a_data)) n_viol++;
            if (!a_ready && gemm_act != '0) n_viol++;
            if (o_last && !o_valid) n_viol++;
            if (done && !busy) n_viol++;
        end
    end

    task automatic check_reset(input string nm);
        chk({nm, "_busy"}, 64'(busy), 0);
        chk({nm, "_done"}, 64'(done), 0);
        chk({nm, "_w_ready"}, 64'(w_ready), 0);
        chk({nm, "_a_ready"}, 64'(a_ready), 0);
        chk({nm, "_o_valid"}, 64'(o_valid), 0);
        chk({nm, "_o_last"}, 64'(o_last), 0);
        chk({nm, "_cmd"}, 64'(gemm_cmd), 64'(CMD_NONE));
        chk({nm, "_weights"}, 64'(gemm_weights), 0);
    endtask

    // Run one job; hold>0 keeps o_ready low until that cycle, stray>0 pulses
    // start (with num_rows=0) mid-job, skip means weight load is expected absent.
    task automatic run_job(input string nm, input int nreq, input int nact, input int nexp,
                           input bit tog, input int hold, input bit keep, input bit skip,
                           input int stray);
        int wi, ai, cyc, dcyc;
        bit got, hs_w, hs_a;
        int s_wr, s_str, s_wrdy, s_whs, s_ahs, s_done, s_viol;
        for (int i = 0; i < nexp; i++) exp_q.push_back('{d: erow[i], l: (i == nexp-1)});
        s_wr = n_wr; s_str = n_str; s_wrdy = n_wrdy; s_whs = n_whs;
        s_ahs = n_ahs; s_done = n_done; s_viol = n_viol;
        o_ready  = (hold == 0);
        start    = 1'b1;
        num_rows = RW'(nreq);
`ifdef GEMM_TILE_SEQ_WEIGHT_REUSE_EN
        keep_w   = keep;
`endif
        wi = 0; ai = 0; cyc = 0; got = 0; dcyc = -1;
        w_valid = 1'b1; w_data = tw[0];
        a_valid = (nact > 0); a_data = arow[0];
        while (!got && cyc < 400) begin
            @(negedge clk);
            if (cyc == 0) chk({nm, "_busy_accept"}, 64'(busy), 1);
            if (hold != 0 && cyc == hold) begin
                chk({nm, "_stall_a_ready"}, 64'(a_ready), 0);
                chk({nm, "_stall_cmd"}, 64'(gemm_cmd), 64'(CMD_NONE));
                chk({nm, "_stall_o_valid"}, 64'(o_valid), 1);
                chk({nm, "_stall_busy"}, 64'(busy), 1);
            end
            hs_w = w_valid && w_ready;
            hs_a = a_valid && a_ready;
            if (done) begin got = 1; dcyc = cyc; end
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
            if (stray != 0 && cyc == stray) begin start = 1'b1; num_rows = '0; end
            if (hold != 0 && cyc == hold + 1) o_ready = 1'b1;
            if (hs_w) wi++;
            w_valid = (wi < SA);
            w_data  = tw[(wi < SA) ? wi : 0];
            if (hs_a) ai++;
            a_valid = (ai < nact) && (!tog || (cyc % 2 == 0));
            a_data  = (ai < nact && ai < 32) ? arow[ai] : '0;
        end
        if (!got) chk({nm, "_timeout"}, 0, 1);
        w_valid = 1'b0; a_valid = 1'b0; o_ready = 1'b1; start = 1'b0;
        chk({nm, "_busy_after"}, 64'(busy), 0);
        chk({nm, "_rows_left"}, 64'(exp_q.size()), 0);
        chk({nm, "_done_pulses"}, 64'(n_done - s_done), 1);
        chk({nm, "_write_w_cycles"}, 64'(n_wr - s_wr), (nexp == 0 || skip) ? 0 : 1);
        chk({nm, "_w_ready_cycles"}, 64'(n_wrdy - s_wrdy), (nexp == 0 || skip) ? 0 : SA);
        chk({nm, "_w_handshakes"}, 64'(n_whs - s_whs), (nexp == 0 || skip) ? 0 : SA);
        chk({nm, "_a_handshakes"}, 64'(n_ahs - s_ahs), 64'(nexp));
        chk({nm, "_stream_cycles"}, 64'(n_str - s_str), (nexp == 0) ? 0 : 64'(nexp + LAT));
        chk({nm, "_invariants"}, 64'(n_viol - s_viol), 0);
        if (nexp == 0) chk({nm, "_done_latency"}, 64'(dcyc), 1);
        exp_q.delete();
    endtask

    task automatic basic_data();
        tw[0] = mkrow(1, 2);
        tw[1] = mkrow(3, 1);
        arow[0] = mkrow(1, 2);
        arow[1] = mkrow(5, 6);
        erow[0] = mkrow(7, 4);
        erow[1] = mkrow(23, 16);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit seen;
        int s_done;
        resetn = 1'b0; start = 1'b0; num_rows = '0;
        w_valid = 1'b0; w_data = '0; a_valid = 1'b0; a_data = '0; o_ready = 1'b1;
`ifdef GEMM_TILE_SEQ_WEIGHT_REUSE_EN
        keep_w = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        check_reset("reset");
        @(posedge clk); #1;

        // Basic 2-row job with hand-computed results
        basic_data();
        run_job("basic", 2, 2, 2, 0, 0, 0, 0, 0);
        chk("weights_hold", 64'(gemm_weights), 64'({mkrow(3, 1), mkrow(1, 2)}));

        // Backpressure: 8 rows with o_ready held low until the FIFO fills
        for (int i = 0; i < 8; i++) begin
            arow[i] = mkrow(i + 1, 2 * i + 3);
            erow[i] = ref_row(arow[i]);
        end
        run_job("bp", 8, 8, 8, 0, 30, 0, 0, 0);

        // Modulo-2^W wrap: 16*16 + 16*16 = 512 -> 0
        tw[0] = mkrow(16, 16); tw[1] = mkrow(16, 16);
        arow[0] = mkrow(16, 16); arow[1] = mkrow(16, 16);
        erow[0] = mkrow(0, 0);   erow[1] = mkrow(0, 0);
        run_job("ovf", 2, 2, 2, 0, 0, 0, 0, 0);

        // Empty job
        run_job("zero", 0, 0, 0, 0, 0, 0, 0, 0);

        // num_rows above MAX_ROWS clamps to 16
        basic_data();
        for (int i = 0; i < 20; i++) begin
            arow[i] = mkrow(i, i + 1);
            if (i < 16) erow[i] = ref_row(arow[i]);
        end
        run_job("clamp", 20, 20, 16, 0, 0, 0, 0, 0);

        // Toggling a_valid plus a stray start mid-job
        for (int i = 0; i < 5; i++) begin
            arow[i] = mkrow(3 * i + 2, 7 - i);
            erow[i] = ref_row(arow[i]);
        end
        run_job("toggle", 5, 5, 5, 1, 0, 0, 0, 5);

        // Reset in the middle of STREAM
        s_done = n_done;
        start = 1'b1; num_rows = RW'(4);
        w_valid = 1'b1; w_data = tw[0];
        a_valid = 1'b1; a_data = arow[0];
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (a_valid && a_ready) seen = 1;
            @(posedge clk); #1;
            start = 1'b0;
            if (seen) break;
        end
        chk("midrst_reached_stream", 64'(seen), 1);
        resetn = 1'b0;
        @(posedge clk); #1;
        check_reset("midrst");
        chk("midrst_no_done", 64'(n_done - s_done), 0);
        exp_q.delete();
        resetn = 1'b1; a_valid = 1'b0; w_valid = 1'b0;
        @(posedge clk); #1;

        // Fresh job after reset reloads weights (keep request ignored)
        basic_data();
        run_job("post_rst", 2, 2, 2, 0, 0, 1, 0, 0);

`ifdef GEMM_TILE_SEQ_WEIGHT_REUSE_EN
        // Reuse job: offered weights differ, results must use the prior tile
        tw[0] = mkrow(99, 99); tw[1] = mkrow(99, 99);
        arow[0] = mkrow(2, 0); arow[1] = mkrow(0, 3);
        erow[0] = mkrow(2, 4); erow[1] = mkrow(9, 3);
        run_job("reuse", 2, 2, 2, 0, 0, 1, 1, 0);
        chk("reuse_weights_kept", 64'(gemm_weights), 64'({mkrow(3, 1), mkrow(1, 2)}));
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
